// File: rtl/reg_fifo_if.sv
// reg_fifo bus: write data/strobe, read strobe, head word, flags.
// master = producer/consumer side, slave = fifo side.
interface reg_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] d;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             udf;

  modport master (
    output d, wr, rd,
    input  q, empty, full, count, ovf, udf
  );

  modport slave (
    input  d, wr, rd,
    output q, empty, full, count, ovf, udf
  );
endinterface

// File: rtl/reg_fifo.sv
// Register-based FIFO, first-word fall-through head on q.
// Ports: clk, nclr (async active-low clear), bus (reg_fifo_if.slave).
module reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       nclr,
  reg_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             ovf_r;
  logic             udf_r;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULLC);

  // A write is taken when full only if a read frees the head
  // slot on the same edge; a read on empty is simply dropped.
  assign push = bus.wr & (~full | bus.rd);
  assign pop  = bus.rd & ~empty;

  // Storage is never cleared; q masks it while empty.
  always_ff @(posedge clk) begin
    if (nclr && push) begin
      mem[wp] <= bus.d;
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case (1'b1)
        push & ~pop: cnt <= cnt + 1'b1;
        pop & ~push: cnt <= cnt - 1'b1;
        default:     cnt <= cnt;
      endcase
      if (bus.wr & ~bus.rd & full) begin
        ovf_r <= 1'b1;
      end
      if (bus.rd & ~bus.wr & empty) begin
        udf_r <= 1'b1;
      end
    end
  end

  assign bus.q     = empty ? '0 : mem[rp];
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.count = cnt;
  assign bus.ovf   = ovf_r;
  assign bus.udf   = udf_r;
endmodule

// File: tb/tb_reg_fifo.sv
// Directed bench for reg_fifo (WIDTH=8, DEPTH=4).
// Vector table plus hand-written reset sequence.
module tb_reg_fifo;
  logic clk;
  logic nclr;
  int   total;
  int   bad;

  reg_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  reg_fifo #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk  (clk),
    .nclr (nclr),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] q;
    logic [2:0] cnt;
    logic       e;
    logic       f;
    logic       o;
    logic       u;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input logic rst, input logic wr, input logic rd,
    input logic [7:0] d, input logic [7:0] q,
    input logic [2:0] cnt, input logic e, input logic f,
    input logic o, input logic u
  );
    vec_t r;
    r.rst = rst; r.wr = wr; r.rd = rd; r.d = d;
    r.q = q; r.cnt = cnt; r.e = e; r.f = f;
    r.o = o; r.u = u;
    return r;
  endfunction

  task automatic check(input string name, input int idx,
                       input vec_t x);
    logic [14:0] act;
    logic [14:0] exp;
    act = {bus.q, bus.count, bus.empty, bus.full,
           bus.ovf, bus.udf};
    exp = {x.q, x.cnt, x.e, x.f, x.o, x.u};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got q=%h cnt=%0d e=%b f=%b o=%b u=%b want q=%h cnt=%0d e=%b f=%b o=%b u=%b",
               name, idx, bus.q, bus.count, bus.empty,
               bus.full, bus.ovf, bus.udf, x.q, x.cnt,
               x.e, x.f, x.o, x.u);
    end
  endtask

  initial begin
    vec_t rv;
    vec_t prev;
    total = 0;
    bad   = 0;
    rv    = v(1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);

    // fill and order, overflow, drain
    tv.push_back(v(0,1,0,8'h12, 8'h12,1,0,0,0,0));
    tv.push_back(v(0,1,0,8'h34, 8'h12,2,0,0,0,0));
    tv.push_back(v(0,1,0,8'h56, 8'h12,3,0,0,0,0));
    tv.push_back(v(0,1,0,8'h78, 8'h12,4,0,1,0,0));
    tv.push_back(v(0,1,0,8'h9A, 8'h12,4,0,1,1,0));
    tv.push_back(v(0,0,1,8'h00, 8'h34,3,0,0,1,0));
    tv.push_back(v(0,0,1,8'h00, 8'h56,2,0,0,1,0));
    tv.push_back(v(0,0,1,8'h00, 8'h78,1,0,0,1,0));
    tv.push_back(v(0,0,1,8'h00, 8'h00,0,1,0,1,0));
    // underflow, then simultaneous access on empty
    tv.push_back(v(0,0,1,8'h00, 8'h00,0,1,0,1,1));
    tv.push_back(v(0,1,1,8'hAB, 8'hAB,1,0,0,1,1));
    tv.push_back(v(0,0,0,8'hFF, 8'hAB,1,0,0,1,1));
    tv.push_back(v(0,0,1,8'h00, 8'h00,0,1,0,1,1));
    // reset with wr high clears flags
    tv.push_back(v(1,1,0,8'hEE, 8'h00,0,1,0,0,0));
    // full simultaneous access and pointer wrap
    tv.push_back(v(0,1,0,8'h01, 8'h01,1,0,0,0,0));
    tv.push_back(v(0,1,0,8'h02, 8'h01,2,0,0,0,0));
    tv.push_back(v(0,1,0,8'h03, 8'h01,3,0,0,0,0));
    tv.push_back(v(0,1,0,8'h04, 8'h01,4,0,1,0,0));
    tv.push_back(v(0,1,1,8'h05, 8'h02,4,0,1,0,0));
    tv.push_back(v(0,1,1,8'h06, 8'h03,4,0,1,0,0));
    tv.push_back(v(0,1,1,8'h07, 8'h04,4,0,1,0,0));
    tv.push_back(v(0,1,1,8'h08, 8'h05,4,0,1,0,0));
    tv.push_back(v(0,1,1,8'h09, 8'h06,4,0,1,0,0));
    tv.push_back(v(0,1,1,8'h0A, 8'h07,4,0,1,0,0));
    tv.push_back(v(0,0,1,8'h00, 8'h08,3,0,0,0,0));
    tv.push_back(v(0,0,1,8'h00, 8'h09,2,0,0,0,0));
    tv.push_back(v(0,0,1,8'h00, 8'h0A,1,0,0,0,0));
    tv.push_back(v(0,0,1,8'h00, 8'h00,0,1,0,0,0));
    // async reset mid-stream with count=3
    tv.push_back(v(0,1,0,8'h11, 8'h11,1,0,0,0,0));
    tv.push_back(v(0,1,0,8'h22, 8'h11,2,0,0,0,0));
    tv.push_back(v(0,1,0,8'h33, 8'h11,3,0,0,0,0));
    tv.push_back(v(1,0,1,8'h00, 8'h00,0,1,0,0,0));
    tv.push_back(v(0,1,0,8'h55, 8'h55,1,0,0,0,0));
    tv.push_back(v(0,0,1,8'h00, 8'h00,0,1,0,0,0));

    // reset held across edges with a write pending
    nclr     = 1'b0;
    bus.wr   = 1'b1;
    bus.rd   = 1'b0;
    bus.d    = 8'h12;
    #1;
    check("reset", 0, rv);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      check("reset", k, rv);
    end

    prev = rv;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      nclr   = ~tv[i].rst;
      bus.wr = tv[i].wr;
      bus.rd = tv[i].rd;
      bus.d  = tv[i].d;
      #1;
      if (tv[i].rst) begin
        // clear must act between edges
        check("rst_async", i, tv[i]);
      end else begin
        // input changes alone must not move state
        check("hold", i, prev);
      end
      @(posedge clk);
      #1;
      check("vec", i, tv[i]);
      prev = tv[i];
    end

    @(negedge clk);
    nclr   = 1'b1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
